// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
//   XLEN     : data width
//   ADDR_W   : register index width
//   NUM_REGS : register count
//   req_e    : writeback requester identity
//   wb_req_t : one writeback request (valid, destination, data)
package regfile_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the execute/memory stages, issue logic and the
// register-file writeback arbiter.
//   issue_*     : destination-register issue handshake (WAW check)
//   rs1/rs2     : source indices under decode, with RAW busy flags
//   alu_*/mem_* : writeback valid/ready requests from ALU and load unit
//   rf_*        : register file write port
//   busy_vec    : scoreboard state, wb_err : sticky unexpected-writeback flag
// slave modport is the arbiter side, master modport is the surrounding pipe.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_rd;
  logic                issue_ready;
  logic [ADDR_W-1:0]   rs1;
  logic [ADDR_W-1:0]   rs2;
  logic                rs1_busy;
  logic                rs2_busy;
  logic                alu_valid;
  logic [ADDR_W-1:0]   alu_rd;
  logic [XLEN-1:0]     alu_data;
  logic                alu_ready;
  logic                mem_valid;
  logic [ADDR_W-1:0]   mem_rd;
  logic [XLEN-1:0]     mem_data;
  logic                mem_ready;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_w;
  logic [XLEN-1:0]     rf_data_in;
  logic [NUM_REGS-1:0] busy_vec;
  logic                wb_err;

  modport slave (
    input  issue_valid, issue_rd, rs1, rs2,
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output issue_ready, rs1_busy, rs2_busy,
    output alu_ready, mem_ready,
    output rf_we, rf_w, rf_data_in, busy_vec, wb_err
  );

  modport master (
    output issue_valid, issue_rd, rs1, rs2,
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  issue_ready, rs1_busy, rs2_busy,
    input  alu_ready, mem_ready,
    input  rf_we, rf_w, rf_data_in, busy_vec, wb_err
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a last-grant flop.
//   clk, resetn : clock, async active-low reset
//   valid[0]    : ALU request, valid[1] : MEM request
//   grant_c     : one-hot grant, combinational from valid and last grant
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] valid,
  output logic [1:0] grant_c
);

  req_e last_grant_q;
  req_e last_grant_d;

  // Contention goes to whoever was not granted last; last grant moves only on a grant.
  always_comb begin
    grant_c      = 2'b00;
    last_grant_d = last_grant_q;
    if (valid == 2'b11) begin
      grant_c = (last_grant_q == REQ_MEM) ? 2'b01 : 2'b10;
    end else begin
      grant_c = valid;
    end
    if (grant_c[0]) begin
      last_grant_d = REQ_ALU;
    end else if (grant_c[1]) begin
      last_grant_d = REQ_MEM;
    end
  end

  // Reset to MEM so the ALU wins the first contention.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= REQ_MEM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter and busy scoreboard.
//   clk, resetn : clock, async active-low reset
//   bus (slave) : issue/decode hazard checks, ALU and load writeback
//                 handshakes, registered register-file write port,
//                 scoreboard debug vector and sticky wb_err.
// One writeback is accepted per cycle and appears on the write port the
// following cycle. Destination registers are marked busy at issue and
// released when their write reaches the register file.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  regfile_wb_arbiter_if.slave  bus
);

  wb_req_t alu_req;
  wb_req_t mem_req;
  wb_req_t win_req;
  logic [1:0] grant;
  logic       transfer;
  logic       issue_set;

  logic                rf_we_q,   rf_we_d;
  logic [ADDR_W-1:0]   rf_w_q,    rf_w_d;
  logic [XLEN-1:0]     rf_data_q, rf_data_d;
  logic [NUM_REGS-1:0] busy_q,    busy_d;
  logic                wb_err_q,  wb_err_d;

  // Pack the two requesters into request structs.
  always_comb begin
    alu_req       = '0;
    alu_req.valid = bus.alu_valid;
    alu_req.rd    = bus.alu_rd;
    alu_req.data  = bus.alu_data;
    mem_req       = '0;
    mem_req.valid = bus.mem_valid;
    mem_req.rd    = bus.mem_rd;
    mem_req.data  = bus.mem_data;
  end

  rr_arbiter2 u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .valid   ({mem_req.valid, alu_req.valid}),
    .grant_c (grant)
  );

  assign bus.alu_ready = grant[0];
  assign bus.mem_ready = grant[1];

  // Winning request; grant is one-hot so the MEM bit selects directly.
  always_comb begin
    win_req  = grant[1] ? mem_req : alu_req;
    transfer = win_req.valid && (grant != 2'b00);
  end

  // WAW check: x0 never blocks, an in-flight write still counts as busy.
  assign bus.issue_ready = (bus.issue_rd == '0) || !busy_q[bus.issue_rd];
  assign issue_set       = bus.issue_valid && bus.issue_ready && (bus.issue_rd != '0);

  // RAW check with bypass of the write happening this cycle.
  assign bus.rs1_busy = busy_q[bus.rs1] && !(rf_we_q && (rf_w_q == bus.rs1)) && (bus.rs1 != '0);
  assign bus.rs2_busy = busy_q[bus.rs2] && !(rf_we_q && (rf_w_q == bus.rs2)) && (bus.rs2 != '0);

  // Next state: write port, scoreboard (set after clear so set wins), error flag.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_w_d    = rf_w_q;
    rf_data_d = rf_data_q;
    busy_d    = busy_q;
    wb_err_d  = wb_err_q;

    if (transfer) begin
      rf_we_d   = (win_req.rd != '0);
      rf_w_d    = win_req.rd;
      rf_data_d = win_req.data;
    end

    if (rf_we_q) begin
      busy_d[rf_w_q] = 1'b0;
      if ((rf_w_q != '0) && !busy_q[rf_w_q]) begin
        wb_err_d = 1'b1;
      end
    end

    if (issue_set) begin
      busy_d[bus.issue_rd] = 1'b1;
    end

    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we_q   <= 1'b0;
      rf_w_q    <= '0;
      rf_data_q <= '0;
      busy_q    <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_w_q    <= rf_w_d;
      rf_data_q <= rf_data_d;
      busy_q    <= busy_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign bus.rf_we      = rf_we_q;
  assign bus.rf_w       = rf_w_q;
  assign bus.rf_data_in = rf_data_q;
  assign bus.busy_vec   = busy_q;
  assign bus.wb_err     = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then protocol-respecting random traffic compared every cycle against a
// behavioural model of the write port, scoreboard and arbitration.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  bit   cmp_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  bit [31:0] m_busy = '0;
  bit        m_we   = 1'b0;
  bit [4:0]  m_w    = '0;
  bit [31:0] m_d    = '0;
  bit        m_last = 1'b1;   // 0 = ALU granted last, 1 = MEM
  bit        m_err  = 1'b0;
  bit        m_wdef = 1'b1;   // rf_w / rf_data_in have a defined expected value

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_alu_grant();
    return bus.alu_valid && (!bus.mem_valid || m_last);
  endfunction

  function automatic bit exp_mem_grant();
    return bus.mem_valid && !exp_alu_grant();
  endfunction

  function automatic bit exp_src_busy(input bit [4:0] rs);
    return (rs != 0) && m_busy[rs] && !(m_we && m_w == rs);
  endfunction

  // Model update at each clock edge; asynchronous reset clears everything.
  always @(posedge clk or negedge resetn) begin
    bit [31:0] nb;
    bit        ga, gm;
    if (!resetn) begin
      m_busy <= '0; m_we <= 1'b0; m_w <= '0; m_d <= '0;
      m_last <= 1'b1; m_err <= 1'b0; m_wdef <= 1'b1;
    end else begin
      ga = exp_alu_grant();
      gm = exp_mem_grant();
      nb = m_busy;
      if (m_we) begin
        if (m_w != 0 && !m_busy[m_w]) m_err <= 1'b1;
        nb[m_w] = 1'b0;
      end
      if (bus.issue_valid && bus.issue_rd != 0 && !m_busy[bus.issue_rd]) nb[bus.issue_rd] = 1'b1;
      nb[0] = 1'b0;
      m_busy <= nb;
      if (ga) begin
        m_we <= (bus.alu_rd != 0); m_w <= bus.alu_rd; m_d <= bus.alu_data;
        m_last <= 1'b0; m_wdef <= (bus.alu_rd != 0);
      end else if (gm) begin
        m_we <= (bus.mem_rd != 0); m_w <= bus.mem_rd; m_d <= bus.mem_data;
        m_last <= 1'b1; m_wdef <= (bus.mem_rd != 0);
      end else begin
        m_we <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("issue_ready", bus.issue_ready, (bus.issue_rd == 0) || !m_busy[bus.issue_rd]);
      check("rs1_busy", bus.rs1_busy, exp_src_busy(bus.rs1));
      check("rs2_busy", bus.rs2_busy, exp_src_busy(bus.rs2));
      check("alu_ready", bus.alu_ready, exp_alu_grant());
      check("mem_ready", bus.mem_ready, exp_mem_grant());
      check("rf_we", bus.rf_we, m_we);
      if (m_we || m_wdef) begin
        check("rf_w", bus.rf_w, m_w);
        check("rf_data_in", bus.rf_data_in, m_d);
      end
      check("busy_vec", bus.busy_vec, m_busy);
      check("wb_err", bus.wb_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Mostly target a register that is currently busy so writebacks look legal.
  function automatic bit [4:0] pick_rd();
    int s;
    if ($urandom_range(0, 4) == 0) return 5'($urandom);
    s = $urandom_range(0, 31);
    for (int i = 0; i < 32; i++) begin
      if (m_busy[(s + i) % 32]) return 5'((s + i) % 32);
    end
    return 5'($urandom);
  endfunction

  initial begin
    bit acc_a, acc_m;
    bus.issue_valid = 0; bus.issue_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1; cmp_en = 1;

    // Reset state.
    at_neg;
    check("rst_busy_vec", bus.busy_vec, 0);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_w", bus.rf_w, 0);
    check("rst_rf_data", bus.rf_data_in, 0);
    check("rst_wb_err", bus.wb_err, 0);

    // Issue rd=5 and observe the hazard flags.
    tick; bus.issue_valid = 1; bus.issue_rd = 5;
    at_neg; check("issue5_ready", bus.issue_ready, 1);
    tick; bus.issue_valid = 0; bus.rs1 = 5;
    at_neg;
    check("busy_after_issue5", bus.busy_vec, 32'h20);
    check("issue5_waw", bus.issue_ready, 0);
    check("rs1_raw5", bus.rs1_busy, 1);

    // ALU writeback alone, with RAW bypass in the write cycle.
    tick; bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
    at_neg; check("alu_only_ready", bus.alu_ready, 1); check("alu_only_mem", bus.mem_ready, 0);
    tick; bus.alu_valid = 0;
    at_neg;
    check("wr5_we", bus.rf_we, 1);
    check("wr5_w", bus.rf_w, 5);
    check("wr5_data", bus.rf_data_in, 32'hDEADBEEF);
    check("wr5_bypass", bus.rs1_busy, 0);
    check("wr5_busy_still", bus.busy_vec, 32'h20);
    tick; at_neg;
    check("wr5_cleared", bus.busy_vec, 0);
    check("wr5_we_drop", bus.rf_we, 0);
    check("wr5_data_hold", bus.rf_data_in, 32'hDEADBEEF);

    // Load writeback to x0: accepted but no write.
    tick; bus.mem_valid = 1; bus.mem_rd = 0; bus.mem_data = 32'h12345678;
    at_neg; check("x0_mem_ready", bus.mem_ready, 1);
    tick; bus.mem_valid = 0;
    at_neg;
    check("x0_no_we", bus.rf_we, 0);
    check("x0_busy", bus.busy_vec, 0);
    check("x0_err", bus.wb_err, 0);

    // Issue rd 1..4, then both requesters contend for four cycles.
    for (int k = 1; k <= 4; k++) begin
      tick; bus.issue_valid = 1; bus.issue_rd = 5'(k);
    end
    tick; bus.issue_valid = 0;
    bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'hA1;
    bus.mem_valid = 1; bus.mem_rd = 2; bus.mem_data = 32'hB2;
    at_neg;
    check("cont_busy", bus.busy_vec, 32'h1E);
    check("cont0_alu", bus.alu_ready, 1); check("cont0_mem", bus.mem_ready, 0);
    tick; bus.alu_rd = 3; bus.alu_data = 32'hA3;
    at_neg;
    check("cont1_alu", bus.alu_ready, 0); check("cont1_mem", bus.mem_ready, 1);
    check("cont1_w", bus.rf_w, 1); check("cont1_data", bus.rf_data_in, 32'hA1);
    tick; bus.mem_rd = 4; bus.mem_data = 32'hB4;
    at_neg;
    check("cont2_alu", bus.alu_ready, 1); check("cont2_w", bus.rf_w, 2);
    tick; bus.alu_valid = 0;
    at_neg;
    check("cont3_mem", bus.mem_ready, 1); check("cont3_w", bus.rf_w, 3);
    tick; bus.mem_valid = 0;
    at_neg;
    check("cont4_we", bus.rf_we, 1); check("cont4_w", bus.rf_w, 4);
    check("cont4_data", bus.rf_data_in, 32'hB4);
    tick; at_neg;
    check("cont_done_busy", bus.busy_vec, 0); check("cont_done_err", bus.wb_err, 0);

    // Writeback to a register that was never issued.
    tick; bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 32'h77;
    at_neg; check("err_pre", bus.wb_err, 0);
    tick; bus.alu_valid = 0;
    at_neg; check("err_we", bus.rf_we, 1); check("err_w", bus.rf_w, 7); check("err_not_yet", bus.wb_err, 0);
    tick; at_neg; check("err_set", bus.wb_err, 1);
    repeat (3) tick;
    at_neg; check("err_sticky", bus.wb_err, 1);

    // Asynchronous reset right after a transfer.
    tick; bus.issue_valid = 1; bus.issue_rd = 1;
    tick; bus.issue_rd = 2;
    tick; bus.issue_valid = 0; bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'h55;
    at_neg; check("prerst_busy", bus.busy_vec, 32'h6); check("prerst_ready", bus.alu_ready, 1);
    @(posedge clk);
    #3 bus.alu_valid = 0; resetn = 0;
    #1;
    check("arst_we", bus.rf_we, 0);
    check("arst_busy", bus.busy_vec, 0);
    check("arst_err", bus.wb_err, 0);
    tick; resetn = 1;
    at_neg; check("postrst_we", bus.rf_we, 0); check("postrst_busy", bus.busy_vec, 0);
    tick; at_neg; check("postrst_we2", bus.rf_we, 0);

    // Random traffic; requesters hold their request until accepted.
    acc_a = 0; acc_m = 0;
    for (int c = 0; c < 2000; c++) begin
      tick;
      if (!bus.alu_valid || acc_a) begin
        bus.alu_valid = ($urandom_range(0, 3) != 0);
        bus.alu_rd    = pick_rd();
        bus.alu_data  = $urandom;
      end
      if (!bus.mem_valid || acc_m) begin
        bus.mem_valid = ($urandom_range(0, 2) != 0);
        bus.mem_rd    = pick_rd();
        bus.mem_data  = $urandom;
      end
      bus.issue_valid = ($urandom_range(0, 1) != 0);
      bus.issue_rd    = 5'($urandom);
      bus.rs1         = 5'($urandom);
      bus.rs2         = ($urandom_range(0, 1) != 0) ? bus.rf_w : 5'($urandom);
      at_neg;
      acc_a = bus.alu_valid && bus.alu_ready;
      acc_m = bus.mem_valid && bus.mem_ready;
    end

    tick;
    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
